// File: rtl/gate_chip_tester.sv
// gate_chip_tester: run-time selectable tester for 2-input logic-gate TTL chips.
// Drives all four input combinations onto every gate, waits for the socket to settle,
// and compares the synchronised gate outputs against the selected truth table.
// Reports pass/fail, a per-gate fail mask and the first failing vector.
module gate_chip_tester #(
  parameter int NUM_GATES     = 4,
  parameter int SETTLE_CYCLES = 50
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [2:0]           Mode,
  input  logic [NUM_GATES-1:0] Dut_Out,
  output logic [NUM_GATES-1:0] A,
  output logic [NUM_GATES-1:0] B,
  output logic                 Drive_En,
  output logic                 Done,
  output logic                 RSLT,
  output logic [NUM_GATES-1:0] Fail_Mask,
  output logic [1:0]           Fail_Vec,
  output logic                 Fail_Valid
);

  // SETTLE_CYCLES-1 always fits in clog2(SETTLE_CYCLES) bits
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [2:0] MODE_NAND = 3'd0;
  localparam logic [2:0] MODE_NOR  = 3'd1;
  localparam logic [2:0] MODE_AND  = 3'd2;
  localparam logic [2:0] MODE_OR   = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [2:0]           mode_q;
  logic [2:0]           mode_nxt;
  logic [1:0]           vec;
  logic [1:0]           vec_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [NUM_GATES-1:0] sync1;
  logic [NUM_GATES-1:0] sync2;

  logic [NUM_GATES-1:0] a_nxt;
  logic [NUM_GATES-1:0] b_nxt;
  logic                 drive_nxt;
  logic                 done_nxt;
  logic                 rslt_nxt;
  logic [NUM_GATES-1:0] mask_nxt;
  logic [1:0]           fvec_nxt;
  logic                 fvalid_nxt;

  logic [NUM_GATES-1:0] vec_a;
  logic [NUM_GATES-1:0] vec_b;
  logic [NUM_GATES-1:0] expected;
  logic [NUM_GATES-1:0] mismatch;

  // Odd gates get the inverted vector so neighbouring pins always sit at opposite levels
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      if (g % 2 == 1) begin
        vec_a[g] = ~vec[1];
        vec_b[g] = ~vec[0];
      end else begin
        vec_a[g] = vec[1];
        vec_b[g] = vec[0];
      end
    end
  end

  // Truth-table value each gate should produce for the inputs currently being driven
  always_comb begin
    expected = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      case (mode_q)
        MODE_NAND: expected[g] = ~(A[g] & B[g]);
        MODE_NOR:  expected[g] = ~(A[g] | B[g]);
        MODE_AND:  expected[g] = A[g] & B[g];
        MODE_OR:   expected[g] = A[g] | B[g];
        MODE_XOR:  expected[g] = A[g] ^ B[g];
        default:   expected[g] = 1'b0;
      endcase
    end
  end

  assign mismatch = expected ^ sync2;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic for every register of the tester
  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    vec_nxt    = vec;
    cnt_nxt    = cnt;
    a_nxt      = A;
    b_nxt      = B;
    drive_nxt  = Drive_En;
    done_nxt   = 1'b0;
    rslt_nxt   = RSLT;
    mask_nxt   = Fail_Mask;
    fvec_nxt   = Fail_Vec;
    fvalid_nxt = Fail_Valid;

    case (state)
      IDLE: begin
        if (Run) begin
          mode_nxt   = Mode;
          vec_nxt    = 2'd0;
          mask_nxt   = '0;
          fvec_nxt   = 2'd0;
          fvalid_nxt = 1'b0;
          rslt_nxt   = 1'b0;
          if (Mode > MODE_XOR) begin
            mask_nxt  = '1;
            state_nxt = DONE;
          end else begin
            state_nxt = APPLY;
          end
        end
      end

      APPLY: begin
        a_nxt     = vec_a;
        b_nxt     = vec_b;
        drive_nxt = 1'b1;
        cnt_nxt   = SETTLE_LOAD;
        state_nxt = SETTLE;
      end

      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      SAMPLE: begin
        mask_nxt = Fail_Mask | mismatch;
        if ((|mismatch) && !Fail_Valid) begin
          fvec_nxt   = vec;
          fvalid_nxt = 1'b1;
        end
        if (vec == 2'd3) begin
          state_nxt = DONE;
        end else begin
          vec_nxt   = vec + 2'd1;
          state_nxt = APPLY;
        end
      end

      DONE: begin
        // Done is raised on the first DONE cycle even if Run already dropped,
        // and afterwards follows Run so the top sees a clean handshake
        done_nxt  = Run | ~Done;
        drive_nxt = 1'b0;
        a_nxt     = '0;
        b_nxt     = '0;
        rslt_nxt  = (Fail_Mask == '0);
        if (!Run) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers, socket drive, results and the free-running input synchroniser
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      mode_q     <= 3'd0;
      vec        <= 2'd0;
      cnt        <= '0;
      sync1      <= '0;
      sync2      <= '0;
      A          <= '0;
      B          <= '0;
      Drive_En   <= 1'b0;
      Done       <= 1'b0;
      RSLT       <= 1'b0;
      Fail_Mask  <= '0;
      Fail_Vec   <= 2'd0;
      Fail_Valid <= 1'b0;
    end else begin
      mode_q     <= mode_nxt;
      vec        <= vec_nxt;
      cnt        <= cnt_nxt;
      sync1      <= Dut_Out;
      sync2      <= sync1;
      A          <= a_nxt;
      B          <= b_nxt;
      Drive_En   <= drive_nxt;
      Done       <= done_nxt;
      RSLT       <= rslt_nxt;
      Fail_Mask  <= mask_nxt;
      Fail_Vec   <= fvec_nxt;
      Fail_Valid <= fvalid_nxt;
    end
  end

endmodule

// File: tb/tb_gate_chip_tester.sv
// tb_gate_chip_tester: quad (4-gate) and hex (6-gate) testers side by side, each with a
// behavioural socket (selectable chip type, stuck outputs, gate0/gate1 short).
// Expected results come from truth tables enumerated over the four test vectors.
module tb_gate_chip_tester;

  localparam int SETTLE = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic run;
  logic [2:0] mode;

  logic [3:0] a4, b4, dout4, mask4;
  logic       de4, done4, rslt4, fvalid4;
  logic [1:0] fvec4;
  logic [5:0] a6, b6, dout6, mask6;
  logic       de6, done6, rslt6, fvalid6;
  logic [1:0] fvec6;

  logic [7:0] obs_a[2], obs_b[2], obs_mask[2];
  logic       obs_de[2], obs_done[2], obs_rslt[2], obs_fvalid[2];
  logic [1:0] obs_fvec[2];

  int       chip[2];
  bit [7:0] sen[2];
  bit [7:0] sval[2];
  bit       sh[2];

  logic [7:0] exp_mask[2];
  logic [1:0] exp_fvec[2];
  logic       exp_fvalid[2];
  logic       exp_rslt[2];

  logic [7:0] sock0, sock1;
  int checks = 0;
  int errors = 0;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  gate_chip_tester #(.NUM_GATES(4), .SETTLE_CYCLES(SETTLE)) dut4 (
    .Clk(clk), .Reset(reset_n), .Run(run), .Mode(mode), .Dut_Out(dout4),
    .A(a4), .B(b4), .Drive_En(de4), .Done(done4), .RSLT(rslt4),
    .Fail_Mask(mask4), .Fail_Vec(fvec4), .Fail_Valid(fvalid4));

  gate_chip_tester #(.NUM_GATES(6), .SETTLE_CYCLES(SETTLE)) dut6 (
    .Clk(clk), .Reset(reset_n), .Run(run), .Mode(mode), .Dut_Out(dout6),
    .A(a6), .B(b6), .Drive_En(de6), .Done(done6), .RSLT(rslt6),
    .Fail_Mask(mask6), .Fail_Vec(fvec6), .Fail_Valid(fvalid6));

  assign obs_a[0] = {4'b0, a4};       assign obs_a[1] = {2'b0, a6};
  assign obs_b[0] = {4'b0, b4};       assign obs_b[1] = {2'b0, b6};
  assign obs_mask[0] = {4'b0, mask4}; assign obs_mask[1] = {2'b0, mask6};
  assign obs_de[0] = de4;             assign obs_de[1] = de6;
  assign obs_done[0] = done4;         assign obs_done[1] = done6;
  assign obs_rslt[0] = rslt4;         assign obs_rslt[1] = rslt6;
  assign obs_fvalid[0] = fvalid4;     assign obs_fvalid[1] = fvalid6;
  assign obs_fvec[0] = fvec4;         assign obs_fvec[1] = fvec6;

  // Truth table lookup, indexed by {a,b}; kinds 0..4 = NAND, NOR, AND, OR, XOR
  function automatic logic tbl(input int k, input logic [1:0] idx);
    logic [3:0] t;
    case (k)
      0: t = 4'b0111;
      1: t = 4'b0001;
      2: t = 4'b1000;
      3: t = 4'b1110;
      4: t = 4'b0110;
      default: t = 4'b0000;
    endcase
    return t[idx];
  endfunction

  // Behavioural chip in the socket, including stuck outputs and a gate0/gate1 wired-OR
  function automatic logic [7:0] socketOut(input int k, input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] s_en, input logic [7:0] s_val,
                                           input bit shorted);
    logic [7:0] o;
    for (int g = 0; g < 8; g++) o[g] = tbl(k, {a[g], b[g]});
    o = (o & ~s_en) | (s_val & s_en);
    if (shorted) begin
      o[0] = o[0] | o[1];
      o[1] = o[0];
    end
    return o;
  endfunction

  // Socket wiring for both testers
  always_comb sock0 = socketOut(chip[0], {4'b0, a4}, {4'b0, b4}, sen[0], sval[0], sh[0]);
  always_comb sock1 = socketOut(chip[1], {2'b0, a6}, {2'b0, b6}, sen[1], sval[1], sh[1]);
  assign dout4 = sock0[3:0];
  assign dout6 = sock1[5:0];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference result: walk the four vectors through the socket model and the mode's table
  task automatic computeExpected(input int m, input int i);
    int n;
    logic [7:0] av, bv, out;
    logic [1:0] ab;
    logic [7:0] mask;
    logic any;
    n = (i == 0) ? 4 : 6;
    exp_fvec[i] = 2'd0;
    exp_fvalid[i] = 1'b0;
    if (m > 4) begin
      exp_mask[i] = 8'((1 << n) - 1);
      exp_rslt[i] = 1'b0;
      return;
    end
    mask = 8'd0;
    for (int v = 0; v < 4; v++) begin
      av = 8'd0;
      bv = 8'd0;
      for (int g = 0; g < n; g++) begin
        ab = 2'(v) ^ ((g % 2 == 1) ? 2'b11 : 2'b00);
        av[g] = ab[1];
        bv[g] = ab[0];
      end
      out = socketOut(chip[i], av, bv, sen[i], sval[i], sh[i]);
      any = 1'b0;
      for (int g = 0; g < n; g++) begin
        if (out[g] !== tbl(m, {av[g], bv[g]})) begin
          mask[g] = 1'b1;
          any = 1'b1;
        end
      end
      if (any && !exp_fvalid[i]) begin
        exp_fvec[i] = 2'(v);
        exp_fvalid[i] = 1'b1;
      end
    end
    exp_mask[i] = mask;
    exp_rslt[i] = (mask == 8'd0);
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_a%0d", tag, i), 32'(obs_a[i]), 32'd0);
      checkOutput($sformatf("%s_b%0d", tag, i), 32'(obs_b[i]), 32'd0);
      checkOutput($sformatf("%s_drive%0d", tag, i), 32'(obs_de[i]), 32'd0);
      checkOutput($sformatf("%s_done%0d", tag, i), 32'(obs_done[i]), 32'd0);
      checkOutput($sformatf("%s_rslt%0d", tag, i), 32'(obs_rslt[i]), 32'd0);
      checkOutput($sformatf("%s_mask%0d", tag, i), 32'(obs_mask[i]), 32'd0);
      checkOutput($sformatf("%s_fvec%0d", tag, i), 32'(obs_fvec[i]), 32'd0);
      checkOutput($sformatf("%s_fvalid%0d", tag, i), 32'(obs_fvalid[i]), 32'd0);
    end
  endtask

  task automatic checkResults(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_rslt%0d", tag, i), 32'(obs_rslt[i]), 32'(exp_rslt[i]));
      checkOutput($sformatf("%s_mask%0d", tag, i), 32'(obs_mask[i]), 32'(exp_mask[i]));
      checkOutput($sformatf("%s_fvalid%0d", tag, i), 32'(obs_fvalid[i]), 32'(exp_fvalid[i]));
      checkOutput($sformatf("%s_fvec%0d", tag, i), 32'(obs_fvec[i]), 32'(exp_fvec[i]));
    end
  endtask

  task automatic setSocket(input int i, input int k, input bit [7:0] s_en, input bit [7:0] s_val, input bit shorted);
    chip[i] = k;
    sen[i] = s_en;
    sval[i] = s_val;
    sh[i] = shorted;
  endtask

  // One complete test: start, latency, results, Done handshake and result retention
  task automatic applyStimulus(input string tag, input int m, input bit hold);
    int lat[2];
    bit de_seen[2];
    int exp_lat;
    computeExpected(m, 0);
    computeExpected(m, 1);
    exp_lat = (m > 4) ? 1 : 4 * (SETTLE + 2) + 1;
    @(negedge clk);
    mode = 3'(m);
    run = 1'b1;
    @(posedge clk);
    lat[0] = -1; lat[1] = -1;
    de_seen[0] = 1'b0; de_seen[1] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!hold) run = 1'b0;
      if (c == 2) mode = 3'($urandom);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (obs_de[i]) de_seen[i] = 1'b1;
        if (obs_done[i] && lat[i] < 0) lat[i] = c;
      end
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_latency%0d", tag, i), 32'(lat[i]), 32'(exp_lat));
      checkOutput($sformatf("%s_drive_seen%0d", tag, i), 32'(de_seen[i]), 32'(m <= 4));
    end
    checkResults(tag);
    if (hold) begin
      for (int j = 0; j < 3; j++) begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
          checkOutput($sformatf("%s_done_held%0d", tag, i), 32'(obs_done[i]), 32'd1);
      end
      @(negedge clk);
      run = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("%s_done_fall%0d", tag, i), 32'(obs_done[i]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkResults({tag, "_kept"});
  endtask

  initial begin
    int m;
    bit hold;
    setSocket(0, 0, 8'h00, 8'h00, 1'b0);
    setSocket(1, 0, 8'h00, 8'h00, 1'b0);
    reset_n = 1'b0;
    run = 1'b0;
    mode = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] NAND pass");
    applyStimulus("nand", 0, 1'b0);

    $display("[TB] NOR with gate 2 stuck low");
    setSocket(0, 1, 8'h04, 8'h00, 1'b0);
    setSocket(1, 1, 8'h04, 8'h00, 1'b0);
    applyStimulus("nor_stuck", 1, 1'b0);

    $display("[TB] AND with gates 0/1 shorted, then clean");
    setSocket(0, 2, 8'h00, 8'h00, 1'b1);
    setSocket(1, 2, 8'h00, 8'h00, 1'b1);
    applyStimulus("and_short", 2, 1'b0);
    setSocket(0, 2, 8'h00, 8'h00, 1'b0);
    setSocket(1, 2, 8'h00, 8'h00, 1'b0);
    applyStimulus("and_clean", 2, 1'b0);

    $display("[TB] invalid mode");
    applyStimulus("invalid", 6, 1'b0);

    $display("[TB] XOR with reset during vector 2 settle");
    setSocket(0, 4, 8'h00, 8'h00, 1'b0);
    setSocket(1, 4, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    mode = 3'd4;
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("midtest_drive%0d", i), 32'(obs_de[i]), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("xor_after_reset", 4, 1'b0);

    $display("[TB] OR with Run held through completion");
    setSocket(0, 3, 8'h00, 8'h00, 1'b0);
    setSocket(1, 3, 8'h00, 8'h00, 1'b0);
    applyStimulus("or_hold", 3, 1'b1);

    $display("[TB] randomized chips, faults and modes");
    for (int r = 0; r < 10; r++) begin
      m = int'($urandom_range(0, 7));
      hold = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2; i++) begin
        setSocket(i,
                  ($urandom_range(0, 1) == 1) ? ((m > 4) ? 0 : m) : int'($urandom_range(0, 4)),
                  ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 5)) : 8'h00,
                  8'($urandom),
                  ($urandom_range(0, 3) == 0));
      end
      applyStimulus($sformatf("rand%0d", r), m, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
